// File: rtl/cafeteria_range_sequencer.sv
// Stream front end for the range-check pipeline: parses header, range and ID words,
// loads the comparator range table, issues queries with flow control and counts hits.
module cafeteria_range_sequencer #(
    parameter int NUM_RANGE       = 182,
    parameter int WIDTH           = 50,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      data_in,
    input  logic             valid_in,
    output logic             ready,
    output logic             tbl_wr_en,
    output logic [7:0]       tbl_wr_addr,
    output logic [WIDTH-1:0] tbl_wr_start,
    output logic [WIDTH-1:0] tbl_wr_end,
    output logic [7:0]       tbl_count,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_id,
    input  logic             r_valid,
    input  logic             r_hit,
    output logic [CNT_W-1:0] result,
    output logic             finished,
    output logic             error
);
    localparam int HI_W = WIDTH - 32;

    typedef enum logic [2:0] {HDR, LOAD, QUERY, DRAIN, DONE} state_t;

    state_t           state_reg;
    logic [1:0]       k_reg;
    logic [CNT_W-1:0] n_rng_reg;
    logic [CNT_W-1:0] n_id_reg;
    logic [CNT_W-1:0] rng_idx_reg;
    logic [CNT_W-1:0] id_idx_reg;
    logic [CNT_W-1:0] issued_reg;
    logic [CNT_W-1:0] returned_reg;
    logic [CNT_W-1:0] result_reg;
    logic [31:0]      start_lo_reg;
    logic [HI_W-1:0]  start_hi_reg;
    logic [31:0]      end_lo_reg;
    logic [31:0]      q_lo_reg;
    logic             tbl_wr_en_reg;
    logic [7:0]       tbl_wr_addr_reg;
    logic [WIDTH-1:0] tbl_wr_start_reg;
    logic [WIDTH-1:0] tbl_wr_end_reg;
    logic [7:0]       tbl_count_reg;
    logic             q_valid_reg;
    logic [WIDTH-1:0] q_id_reg;
    logic             error_reg;

    logic [CNT_W-1:0] outstanding;
    logic             accept;
    logic             ret_ok;
    logic [CNT_W-1:0] hdr_rng;
    logic [CNT_W-1:0] hdr_id;
    logic [WIDTH-1:0] start_full;
    logic [WIDTH-1:0] end_full;
    logic             rng_last;
    logic             id_last;
    logic [7:0]       count_next;

    assign outstanding = issued_reg - returned_reg;
    assign hdr_rng     = CNT_W'(data_in[15:0]);
    assign hdr_id      = CNT_W'(data_in[31:16]);
    assign start_full  = {start_hi_reg, start_lo_reg};
    assign end_full    = {data_in[HI_W-1:0], end_lo_reg};
    assign rng_last    = (rng_idx_reg == n_rng_reg - CNT_W'(1));
    assign id_last     = (id_idx_reg == n_id_reg - CNT_W'(1));
    assign count_next  = rng_idx_reg[7:0] + 8'd1;
    assign ret_ok      = r_valid && (outstanding != '0);

    // Only the lo word of an ID is throttled, so an ID is never split across a stall.
    always_comb begin
        ready = 1'b0;
        case (state_reg)
            HDR, LOAD: ready = 1'b1;
            QUERY:     ready = k_reg[0] || (outstanding < CNT_W'(MAX_OUTSTANDING));
            default:   ready = 1'b0;
        endcase
    end

    assign accept = valid_in && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= HDR;
            k_reg            <= '0;
            n_rng_reg        <= '0;
            n_id_reg         <= '0;
            rng_idx_reg      <= '0;
            id_idx_reg       <= '0;
            issued_reg       <= '0;
            returned_reg     <= '0;
            result_reg       <= '0;
            start_lo_reg     <= '0;
            start_hi_reg     <= '0;
            end_lo_reg       <= '0;
            q_lo_reg         <= '0;
            tbl_wr_en_reg    <= 1'b0;
            tbl_wr_addr_reg  <= '0;
            tbl_wr_start_reg <= '0;
            tbl_wr_end_reg   <= '0;
            tbl_count_reg    <= '0;
            q_valid_reg      <= 1'b0;
            q_id_reg         <= '0;
            error_reg        <= 1'b0;
        end else begin
            tbl_wr_en_reg <= 1'b0;
            q_valid_reg   <= 1'b0;

            if (ret_ok) begin
                returned_reg <= returned_reg + CNT_W'(1);
                if (r_hit) begin
                    result_reg <= result_reg + CNT_W'(1);
                end
            end

            case (state_reg)
                HDR: begin
                    if (accept) begin
                        n_rng_reg   <= hdr_rng;
                        n_id_reg    <= hdr_id;
                        rng_idx_reg <= '0;
                        id_idx_reg  <= '0;
                        k_reg       <= '0;
                        if (hdr_rng > CNT_W'(NUM_RANGE)) begin
                            error_reg <= 1'b1;
                        end
                        if (hdr_rng != '0) begin
                            state_reg <= LOAD;
                        end else if (hdr_id != '0) begin
                            state_reg <= QUERY;
                        end else begin
                            state_reg <= DONE;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        k_reg <= k_reg + 2'd1;
                        case (k_reg)
                            2'd0: start_lo_reg <= data_in;
                            2'd1: start_hi_reg <= data_in[HI_W-1:0];
                            2'd2: end_lo_reg   <= data_in;
                            default: begin
                                // Ranges past the table capacity are consumed but never written.
                                if (rng_idx_reg < CNT_W'(NUM_RANGE)) begin
                                    tbl_wr_en_reg   <= 1'b1;
                                    tbl_wr_addr_reg <= rng_idx_reg[7:0];
                                    tbl_count_reg   <= count_next;
                                    if (start_full > end_full) begin
                                        tbl_wr_start_reg <= end_full;
                                        tbl_wr_end_reg   <= start_full;
                                    end else begin
                                        tbl_wr_start_reg <= start_full;
                                        tbl_wr_end_reg   <= end_full;
                                    end
                                end
                                rng_idx_reg <= rng_idx_reg + CNT_W'(1);
                                if (rng_last) begin
                                    state_reg <= (n_id_reg != '0) ? QUERY : DONE;
                                end
                            end
                        endcase
                    end
                end
                QUERY: begin
                    if (accept) begin
                        if (!k_reg[0]) begin
                            q_lo_reg <= data_in;
                            k_reg    <= 2'd1;
                        end else begin
                            q_valid_reg <= 1'b1;
                            q_id_reg    <= {data_in[HI_W-1:0], q_lo_reg};
                            issued_reg  <= issued_reg + CNT_W'(1);
                            id_idx_reg  <= id_idx_reg + CNT_W'(1);
                            k_reg       <= 2'd0;
                            if (id_last) begin
                                state_reg <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (returned_reg == n_id_reg) begin
                        state_reg <= DONE;
                    end
                end
                default: state_reg <= DONE;
            endcase
        end
    end

    assign tbl_wr_en    = tbl_wr_en_reg;
    assign tbl_wr_addr  = tbl_wr_addr_reg;
    assign tbl_wr_start = tbl_wr_start_reg;
    assign tbl_wr_end   = tbl_wr_end_reg;
    assign tbl_count    = tbl_count_reg;
    assign q_valid      = q_valid_reg;
    assign q_id         = q_id_reg;
    assign result       = result_reg;
    assign finished     = (state_reg == DONE);
    assign error        = error_reg;

endmodule

// File: tb/tb_cafeteria_range_sequencer.sv
// Randomized bench: a stream-level model predicts table writes, queries and the hit count,
// while a latency-3 datapath model answers queries from the table the DUT writes.
module tb_cafeteria_range_sequencer;
    localparam int NUM_RANGE = 182;
    localparam int WIDTH     = 50;
    localparam int MAXO      = 2;
    localparam int CNT_W     = 16;
    localparam int LAT       = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [31:0]      data_in = '0;
    logic             valid_in = 1'b0;
    logic             ready;
    logic             tbl_wr_en;
    logic [7:0]       tbl_wr_addr;
    logic [WIDTH-1:0] tbl_wr_start;
    logic [WIDTH-1:0] tbl_wr_end;
    logic [7:0]       tbl_count;
    logic             q_valid;
    logic [WIDTH-1:0] q_id;
    logic             r_valid = 1'b0;
    logic             r_hit = 1'b0;
    logic [CNT_W-1:0] result;
    logic             finished;
    logic             error;

    cafeteria_range_sequencer #(
        .NUM_RANGE(NUM_RANGE), .WIDTH(WIDTH), .MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .ready(ready),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_start(tbl_wr_start),
        .tbl_wr_end(tbl_wr_end), .tbl_count(tbl_count), .q_valid(q_valid), .q_id(q_id),
        .r_valid(r_valid), .r_hit(r_hit), .result(result), .finished(finished), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] addr; logic [49:0] rs; logic [49:0] re; logic [7:0] cnt;} wr_t;
    typedef struct {bit hit; longint due; int ep;} pend_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] stream[$];
    logic [49:0] gen_s[$], gen_e[$], gen_id[$];
    wr_t         exp_wr[$];
    logic [49:0] exp_q[$];
    pend_t       pend[$];
    int          exp_result, exp_count;
    bit          exp_error;
    bit          aborted;
    int          n_wr, n_q, n_ret;
    int          epoch = 0;
    bit          hold = 1'b0;
    int          pulse_budget = 0, pulses_done = 0;
    longint      cyc = 0;
    logic [49:0] dp_s[256], dp_e[256];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [49:0] rand_val();
        return {18'($urandom_range(0, 1)), 32'($urandom_range(0, 300))};
    endfunction

    // Expected behaviour derived straight from the stream rules.
    task automatic build();
        logic [49:0] ks[$], ke[$];
        logic [49:0] s, e, id;
        bit hit;
        stream.delete(); exp_wr.delete(); exp_q.delete();
        exp_result = 0;
        aborted = 1'b0;
        stream.push_back({16'(gen_id.size()), 16'(gen_s.size())});
        exp_error = gen_s.size() > NUM_RANGE;
        exp_count = (gen_s.size() > NUM_RANGE) ? NUM_RANGE : gen_s.size();
        foreach (gen_s[i]) begin
            s = gen_s[i];
            e = gen_e[i];
            stream.push_back(s[31:0]);
            stream.push_back({14'($urandom), s[49:32]});
            stream.push_back(e[31:0]);
            stream.push_back({14'($urandom), e[49:32]});
            if (i < NUM_RANGE) begin
                ks.push_back((s > e) ? e : s);
                ke.push_back((s > e) ? s : e);
                exp_wr.push_back('{addr: 8'(i), rs: ks[i], re: ke[i], cnt: 8'(i + 1)});
            end
        end
        foreach (gen_id[i]) begin
            id = gen_id[i];
            stream.push_back(id[31:0]);
            stream.push_back({14'($urandom), id[49:32]});
            exp_q.push_back(id);
            hit = 1'b0;
            foreach (ks[j]) if (id >= ks[j] && id <= ke[j]) hit = 1'b1;
            if (hit) exp_result++;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        int budget = 0;
        if (aborted) return;
        @(negedge clk);
        if (gaps && $urandom_range(0, 3) == 0) begin
            valid_in = 1'b0;
            @(negedge clk);
        end
        data_in  = w;
        valid_in = 1'b1;
        while (!ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 300) begin
            check("send_timeout", 1, 0);
            aborted  = 1'b1;
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
    endtask

    task automatic send_all(input bit gaps);
        foreach (stream[i]) send_word(stream[i], gaps);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int budget = 0;
        while (!finished && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 3000) check({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic final_checks(input string name);
        repeat (3) @(negedge clk);
        check({name, "_finished"}, finished, 1);
        check({name, "_ready"}, ready, 0);
        check({name, "_result"}, result, exp_result);
        check({name, "_error"}, error, exp_error);
        check({name, "_tbl_count"}, tbl_count, exp_count);
        check({name, "_writes_left"}, exp_wr.size(), 0);
        check({name, "_queries_left"}, exp_q.size(), 0);
        $display("scenario %s: writes %0d queries %0d result %0d", name, n_wr, n_q, result);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ready"}, ready, 1);
        check({name, "_wr_en"}, tbl_wr_en, 0);
        check({name, "_wr_addr"}, tbl_wr_addr, 0);
        check({name, "_wr_start"}, tbl_wr_start, 0);
        check({name, "_wr_end"}, tbl_wr_end, 0);
        check({name, "_count"}, tbl_count, 0);
        check({name, "_q_valid"}, q_valid, 0);
        check({name, "_q_id"}, q_id, 0);
        check({name, "_result"}, result, 0);
        check({name, "_finished"}, finished, 0);
        check({name, "_error"}, error, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        n_wr = 0; n_q = 0; n_ret = 0;
        epoch++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic gen_random(input int nr, input int nid);
        gen_s.delete(); gen_e.delete(); gen_id.delete();
        for (int i = 0; i < nr; i++) begin
            gen_s.push_back(rand_val());
            gen_e.push_back(rand_val());
        end
        for (int i = 0; i < nid; i++) gen_id.push_back(rand_val());
    endtask

    always @(posedge clk) cyc++;

    // Monitor: scoreboards table writes and queries, feeds the datapath model.
    always @(negedge clk) begin
        wr_t w;
        logic [49:0] eq;
        bit hit;
        if (!rst) begin
            if (tbl_wr_en) begin
                n_wr++;
                $display("WR addr %0d start 0x%0h end 0x%0h count %0d",
                         tbl_wr_addr, tbl_wr_start, tbl_wr_end, tbl_count);
                dp_s[tbl_wr_addr] = tbl_wr_start;
                dp_e[tbl_wr_addr] = tbl_wr_end;
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", tbl_wr_addr, w.addr);
                    check("wr_start", tbl_wr_start, w.rs);
                    check("wr_end", tbl_wr_end, w.re);
                    check("wr_count", tbl_count, w.cnt);
                end
            end
            if (q_valid) begin
                n_q++;
                hit = 1'b0;
                for (int j = 0; j < 256; j++)
                    if (j < int'(tbl_count) && q_id >= dp_s[j] && q_id <= dp_e[j]) hit = 1'b1;
                pend.push_back('{hit: hit, due: cyc + LAT, ep: epoch});
                $display("Q id 0x%0h hit %0d issued %0d returned %0d", q_id, hit, n_q, n_ret);
                check("outstanding_le_max", (n_q - n_ret) <= MAXO, 1);
                if (exp_q.size() == 0) begin
                    check("q_unexpected", 1, 0);
                end else begin
                    eq = exp_q.pop_front();
                    check("q_id", q_id, eq);
                end
            end
        end
    end

    // Datapath model: in-order returns after LAT cycles, or single pulses on request while held.
    always @(posedge clk) begin
        pend_t p;
        #1;
        if (pend.size() > 0 && ((!hold && pend[0].due <= cyc) || (hold && pulses_done < pulse_budget))) begin
            p = pend.pop_front();
            if (hold) pulses_done++;
            r_valid = 1'b1;
            r_hit   = p.hit;
            if (p.ep == epoch) n_ret++;
        end else begin
            r_valid = 1'b0;
            r_hit   = 1'b0;
        end
    end

    initial begin
        int budget;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // Two small ranges, three IDs.
        do_reset();
        gen_s = '{50'd3, 50'd10};
        gen_e = '{50'd5, 50'd14};
        gen_id = '{50'd5, 50'd8, 50'd11};
        build();
        check("basic_header", stream[0], 32'h0003_0002);
        send_all(1'b1);
        wait_done("basic");
        final_checks("basic");
        check("basic_writes", n_wr, 2);
        check("basic_queries", n_q, 3);

        // Descending range spanning the 32-bit boundary.
        do_reset();
        gen_s = '{50'h3_0000_0000};
        gen_e = '{50'h2_FFFF_FFFF};
        gen_id = '{50'h3_0000_0000, 50'h1};
        build();
        send_all(1'b0);
        wait_done("swap");
        final_checks("swap");
        check("swap_start", tbl_wr_start, 50'h2_FFFF_FFFF);
        check("swap_end", tbl_wr_end, 50'h3_0000_0000);

        // Throttling with returns withheld; second return lands on an issue cycle.
        do_reset();
        gen_random(1, 5);
        build();
        hold = 1'b1;
        fork
            send_all(1'b0);
            begin
                budget = 0;
                while (n_q < 2 && budget < 200) begin
                    @(negedge clk);
                    budget++;
                end
                repeat (10) @(negedge clk);
                check("max_issued", n_q, 2);
                check("max_ready", ready, 0);
                pulse_budget++;
                @(negedge clk);
                @(negedge clk);
                pulse_budget++;
                repeat (15) @(negedge clk);
                check("coinc_issued", n_q, 4);
                check("coinc_ready", ready, 0);
                hold = 1'b0;
            end
        join
        wait_done("max");
        final_checks("max");

        // Range count beyond table capacity.
        do_reset();
        gen_random(200, 4);
        gen_id[0] = gen_s[5];
        gen_id[1] = gen_s[190];
        build();
        send_all(1'b0);
        wait_done("overflow");
        final_checks("overflow");
        check("overflow_writes", n_wr, NUM_RANGE);

        // Empty header.
        do_reset();
        gen_s.delete(); gen_e.delete(); gen_id.delete();
        build();
        send_word(stream[0], 1'b0);
        @(negedge clk);
        check("empty_finished", finished, 1);
        check("empty_ready", ready, 0);
        check("empty_result", result, 0);
        repeat (5) @(negedge clk);
        valid_in = 1'b0;
        check("empty_writes", n_wr, 0);
        check("empty_queries", n_q, 0);

        // Reset in the middle of QUERY with queries outstanding; stale hits must be ignored.
        do_reset();
        gen_s = '{50'd0};
        gen_e = '{50'd1000};
        gen_id = '{50'd1, 50'd2, 50'd3, 50'd4, 50'd5, 50'd6};
        build();
        hold = 1'b1;
        for (int i = 0; i < 9; i++) send_word(stream[i], 1'b0);
        budget = 0;
        while (n_q < 2 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("abort_outstanding", n_q - n_ret, 2);
        rst = 1'b1;
        valid_in = 1'b0;
        hold = 1'b0;
        n_wr = 0; n_q = 0; n_ret = 0;
        epoch++;
        @(negedge clk);
        check_reset_vals("abort");
        @(negedge clk);
        rst = 1'b0;
        gen_random(3, 6);
        build();
        send_all(1'b1);
        wait_done("after_abort");
        final_checks("after_abort");

        // Random streams with idle gaps.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            gen_random($urandom_range(1, 6), $urandom_range(1, 10));
            build();
            send_all(1'b1);
            wait_done("random");
            final_checks("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
